// File: rtl/dtw_pkg.sv
// Shared types and constants for the DTW word requester: word geometry,
// controller state encoding, output marker characters and byte selection.
package dtw_pkg;

  localparam int CHAR_W   = 8;
  localparam int CHAR_NUM = 15;
  localparam int WORD_W   = CHAR_W * CHAR_NUM;
  localparam int IDX_W    = 4;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [CHAR_W-1:0] char_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam char_t SEP_CHAR     = 8'h20;
  localparam char_t NOMATCH_CHAR = 8'h3F;

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_EMIT    = 3'd3,
    S_CLEAR   = 3'd4
  } state_t;

  // Byte idx of a packed word; indices past the last character read as zero.
  function automatic char_t get_byte(input word_t w, input idx_t idx);
    if (idx >= idx_t'(CHAR_NUM)) return '0;
    return w[int'(idx)*CHAR_W +: CHAR_W];
  endfunction

endpackage

// File: rtl/dtw_word_requester_if.sv
// Character input, matcher start/finish and result stream of the requester,
// bundled as one interface. The master side is the requester itself.
interface dtw_word_requester_if;
  import dtw_pkg::*;

  logic  i_char_valid;
  char_t i_char;
  logic  o_char_ready;
  logic  i_word_end;
  logic  o_DTW_start;
  word_t o_DTW_word;
  logic  i_DTW_finish;
  word_t i_DTW_word;
  logic  o_res_valid;
  char_t o_res_char;
  logic  i_res_ready;
  logic  o_overflow;
  logic  o_err;
  logic  [2:0] o_state;

  modport master (
    input  i_char_valid, i_char, i_word_end, i_DTW_finish, i_DTW_word, i_res_ready,
    output o_char_ready, o_DTW_start, o_DTW_word, o_res_valid, o_res_char,
           o_overflow, o_err, o_state
  );

  modport slave (
    output i_char_valid, i_char, i_word_end, i_DTW_finish, i_DTW_word, i_res_ready,
    input  o_char_ready, o_DTW_start, o_DTW_word, o_res_valid, o_res_char,
           o_overflow, o_err, o_state
  );
endinterface

// File: rtl/dtw_res_serializer.sv
// Streams a matched word out byte by byte over valid/ready, stopping at the
// first zero byte, substituting '?' for an empty match, and ending with a separator.
module dtw_res_serializer
  import dtw_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  word_t word,
  input  logic  ready,
  output logic  valid,
  output char_t res_char,
  output logic  done
);

  word_t res_q;
  idx_t  idx_q;
  logic  nomatch_q;
  logic  is_sep_q;
  logic  valid_q;
  char_t char_q;

  logic  hs;
  logic  more;
  char_t first;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    hs    = valid_q && ready;
    more  = 1'b0;
    first = get_byte(word, idx_t'(0));
    if (!nomatch_q && idx_q != idx_t'(CHAR_NUM))
      more = (get_byte(res_q, idx_q) != '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '0;
      idx_q     <= '0;
      nomatch_q <= 1'b0;
      is_sep_q  <= 1'b0;
      valid_q   <= 1'b0;
      char_q    <= '0;
    end else if (load) begin
      res_q     <= word;
      idx_q     <= idx_t'(1);
      nomatch_q <= (first == '0);
      char_q    <= (first == '0) ? NOMATCH_CHAR : first;
      is_sep_q  <= 1'b0;
      valid_q   <= 1'b1;
    end else if (hs) begin
      if (is_sep_q) begin
        valid_q  <= 1'b0;
        is_sep_q <= 1'b0;
      end else if (more) begin
        char_q <= get_byte(res_q, idx_q);
        idx_q  <= idx_q + idx_t'(1);
      end else begin
        char_q   <= SEP_CHAR;
        is_sep_q <= 1'b1;
      end
    end
  end

  assign valid    = valid_q;
  assign res_char = char_q;
  assign done     = hs && is_sep_q;

endmodule

// File: rtl/dtw_word_requester.sv
// Collects gesture characters into a packed word, starts the DTW matcher,
// waits for its finish (with timeout) and hands the result to the serializer.
module dtw_word_requester
  import dtw_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 1000,
  parameter int WAIT_MAX     = 4096
) (
  input logic i_DTW_clk,
  input logic i_DTW_rst_n,
  dtw_word_requester_if.master bus
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int WW = $clog2(WAIT_MAX);

  state_t         state_q, state_d;
  word_t          word_q;
  idx_t           count_q;
  logic [IW-1:0]  idle_q;
  logic [WW-1:0]  wait_q;
  logic           overflow_q;
  logic           err_q;

  logic accept, store, close, timeout, load, done;
  logic char_ready, start;
  idx_t count_after;

  always_comb begin
    accept      = bus.i_char_valid && char_ready;
    store       = accept && bus.i_char != '0 && count_q != idx_t'(CHAR_NUM);
    count_after = store ? count_q + idx_t'(1) : count_q;
    close       = (bus.i_word_end && count_after != '0) ||
                  (idle_q == IW'(IDLE_TIMEOUT) && count_q != '0);
    timeout     = (wait_q == WW'(WAIT_MAX - 1));
  end

  always_ff @(posedge i_DTW_clk or negedge i_DTW_rst_n) begin
    if (!i_DTW_rst_n) state_q <= S_COLLECT;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: if (close) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT: begin
        if (bus.i_DTW_finish) state_d = S_EMIT;
        else if (timeout)     state_d = S_CLEAR;
      end
      S_EMIT:    if (done) state_d = S_CLEAR;
      S_CLEAR:   state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    char_ready = (state_q == S_COLLECT);
    start      = (state_q == S_ISSUE);
    load       = (state_q == S_WAIT) && bus.i_DTW_finish;
  end

  // The word buffer only changes in S_COLLECT and S_CLEAR, so it is stable
  // for the matcher from S_ISSUE until S_WAIT is left.
  always_ff @(posedge i_DTW_clk or negedge i_DTW_rst_n) begin
    if (!i_DTW_rst_n) begin
      word_q     <= '0;
      count_q    <= '0;
      idle_q     <= '0;
      wait_q     <= '0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wait_q <= '0;
      case (state_q)
        S_COLLECT: begin
          if (accept) begin
            idle_q <= '0;
            if (store) begin
              word_q[int'(count_q)*CHAR_W +: CHAR_W] <= bus.i_char;
              count_q <= count_after;
            end else if (bus.i_char != '0) begin
              overflow_q <= 1'b1;
            end
          end else if (idle_q != IW'(IDLE_TIMEOUT)) begin
            idle_q <= idle_q + IW'(1);
          end
        end
        S_WAIT: begin
          wait_q <= wait_q + WW'(1);
          if (timeout && !bus.i_DTW_finish) err_q <= 1'b1;
        end
        S_CLEAR: begin
          word_q     <= '0;
          count_q    <= '0;
          idle_q     <= '0;
          overflow_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  dtw_res_serializer u_ser (
    .clk      (i_DTW_clk),
    .rst_n    (i_DTW_rst_n),
    .load     (load),
    .word     (bus.i_DTW_word),
    .ready    (bus.i_res_ready),
    .valid    (bus.o_res_valid),
    .res_char (bus.o_res_char),
    .done     (done)
  );

  assign bus.o_char_ready = char_ready;
  assign bus.o_DTW_start  = start;
  assign bus.o_DTW_word   = word_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_err        = err_q;
  assign bus.o_state      = state_q;

endmodule

// File: tb/tb_dtw_word_requester.sv
// Randomised self-checking bench for dtw_word_requester: the bench plays the
// matcher and the downstream sink, and predicts words and emitted bytes.
module tb_dtw_word_requester;
  import dtw_pkg::*;

  localparam int IDLE_T = 1000;
  localparam int WAIT_T = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dtw_word_requester_if bus ();

  dtw_word_requester #(.IDLE_TIMEOUT(IDLE_T), .WAIT_MAX(WAIT_T)) dut (
    .i_DTW_clk   (clk),
    .i_DTW_rst_n (rst_n),
    .bus         (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: nonzero chars in order, first fifteen kept, rest flag overflow.
  function automatic logic [119:0] model_pack(input logic [7:0] q[$]);
    logic [119:0] w = '0;
    int k = 0;
    foreach (q[i]) if (q[i] != 8'h00) begin
      if (k < 15) w[k*8 +: 8] = q[i];
      k++;
    end
    return w;
  endfunction

  function automatic bit model_ovf(input logic [7:0] q[$]);
    int k = 0;
    foreach (q[i]) if (q[i] != 8'h00) k++;
    return k > 15;
  endfunction

  function automatic void model_emit(input logic [119:0] r, output logic [7:0] s[$]);
    s = {};
    if (r[7:0] == 8'h00) s.push_back(8'h3F);
    else begin
      for (int i = 0; i < 15; i++) begin
        if (r[i*8 +: 8] == 8'h00) break;
        s.push_back(r[i*8 +: 8]);
      end
    end
    s.push_back(8'h20);
  endfunction

  // mode: 0 = word_end on its own cycle, 1 = word_end with last char, 2 = idle close.
  // ready_mode: 0 = always ready, 1 = toggling 1/0, 2 = random.
  task automatic run_txn(input string name, input logic [7:0] chars[$], input int mode,
                         input logic [119:0] resp, input bit give_finish, input int ready_mode);
    logic [119:0] exp_w;
    logic [7:0]   exp_s[$];
    logic [7:0]   got[$];
    int  j, cyc, unstable, dly;
    bit  pend, saw_valid;
    logic [7:0] pend_char;
    logic rdy;

    exp_w = model_pack(chars);
    model_emit(resp, exp_s);
    foreach (chars[i]) begin
      @(negedge clk);
      if (i == 0) check({name, "_char_ready"}, bus.o_char_ready, 1'b1);
      bus.i_char_valid = 1'b1;
      bus.i_char       = chars[i];
      bus.i_word_end   = (mode == 1) && (i == chars.size() - 1);
    end
    if (mode == 0) begin
      @(negedge clk);
      bus.i_char_valid = 1'b0;
      bus.i_word_end   = 1'b1;
    end
    @(negedge clk);
    bus.i_char_valid = 1'b0;
    bus.i_word_end   = 1'b0;
    bus.i_char       = 8'h00;
    if (mode == 2) begin
      j = 1;
      while (!bus.o_DTW_start && j < IDLE_T + 10) begin
        @(negedge clk);
        j++;
      end
      check({name, "_idle_close_window"}, (j >= IDLE_T && j <= IDLE_T + 2), 1'b1);
    end
    check({name, "_start"}, bus.o_DTW_start, 1'b1);
    if (!bus.o_DTW_start) return;
    check({name, "_word"}, bus.o_DTW_word, exp_w);
    check({name, "_overflow"}, bus.o_overflow, model_ovf(chars));
    check({name, "_state_issue"}, bus.o_state, 3'd1);
    @(negedge clk);
    check({name, "_start_one_cycle"}, bus.o_DTW_start, 1'b0);
    check({name, "_state_wait"}, bus.o_state, 3'd2);

    if (give_finish) begin
      unstable = 0;
      dly = $urandom_range(0, 8);
      repeat (dly) begin
        @(negedge clk);
        if (bus.o_DTW_word !== exp_w) unstable++;
      end
      bus.i_DTW_finish = 1'b1;
      bus.i_DTW_word   = resp;
      @(negedge clk);
      bus.i_DTW_finish = 1'b0;
      bus.i_DTW_word   = {$urandom, $urandom, $urandom, $urandom};
      check({name, "_word_stable"}, unstable, 0);
      check({name, "_first_valid"}, bus.o_res_valid, 1'b1);
      cyc = 0; pend = 1'b0; pend_char = '0; unstable = 0;
      while (bus.o_state != 3'd0 && cyc < 300) begin
        case (ready_mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        bus.i_res_ready = rdy;
        if (pend && (!bus.o_res_valid || bus.o_res_char !== pend_char)) unstable++;
        if (bus.o_res_valid && rdy) got.push_back(bus.o_res_char);
        pend      = bus.o_res_valid && !rdy;
        pend_char = bus.o_res_char;
        @(negedge clk);
        cyc++;
      end
      bus.i_res_ready = 1'b0;
      check({name, "_emit_done"}, bus.o_state, 3'd0);
      check({name, "_held_until_ready"}, unstable, 0);
      check({name, "_emit_len"}, got.size(), exp_s.size());
      foreach (exp_s[i])
        check({name, "_emit_byte"}, (i < got.size()) ? got[i] : 8'hxx, exp_s[i]);
      if (ready_mode == 0)
        check({name, "_one_per_cycle"}, cyc, exp_s.size() + 1);
    end else begin
      j = 0; saw_valid = 1'b0;
      while (bus.o_state != 3'd0 && j < WAIT_T + 20) begin
        if (bus.o_res_valid) saw_valid = 1'b1;
        @(negedge clk);
        j++;
      end
      check({name, "_timeout_window"}, (j >= WAIT_T && j <= WAIT_T + 2), 1'b1);
      check({name, "_err"}, bus.o_err, 1'b1);
      check({name, "_no_result"}, saw_valid, 1'b0);
    end
    check({name, "_overflow_cleared"}, bus.o_overflow, 1'b0);
    check({name, "_word_cleared"}, bus.o_DTW_word, 120'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [119:0] r;
    int starts, n;

    bus.i_char_valid = 1'b0;
    bus.i_char       = 8'h00;
    bus.i_word_end   = 1'b0;
    bus.i_DTW_finish = 1'b0;
    bus.i_DTW_word   = '0;
    bus.i_res_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", bus.o_state, 3'd0);
    check("rst_char_ready", bus.o_char_ready, 1'b1);
    check("rst_outputs", {bus.o_DTW_start, bus.o_res_valid, bus.o_res_char,
                          bus.o_overflow, bus.o_err}, '0);
    check("rst_word", bus.o_DTW_word, 120'd0);
    rst_n = 1'b1;

    // Reset while waiting on the matcher.
    q = '{8'h43, 8'h41, 8'h54};
    foreach (q[i]) begin
      @(negedge clk);
      bus.i_char_valid = 1'b1;
      bus.i_char       = q[i];
    end
    @(negedge clk);
    bus.i_char_valid = 1'b0;
    bus.i_word_end   = 1'b1;
    @(negedge clk);
    bus.i_word_end = 1'b0;
    repeat (4) @(negedge clk);
    check("midwait_state", bus.o_state, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    check("midwait_rst_state", bus.o_state, 3'd0);
    check("midwait_rst_ready", bus.o_char_ready, 1'b1);
    check("midwait_rst_word", bus.o_DTW_word, 120'd0);
    check("midwait_rst_outs", {bus.o_DTW_start, bus.o_res_valid, bus.o_overflow, bus.o_err}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    starts = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_DTW_start) starts++;
    end
    check("no_start_after_rst", starts, 0);

    run_txn("cat", '{8'h43, 8'h41, 8'h54}, 0, 120'h524143, 1'b1, 0);
    check("cat_packed_literal", model_pack('{8'h43, 8'h41, 8'h54}), 120'h544143);

    q = {};
    repeat (17) q.push_back(8'h41);
    run_txn("ovf17", q, 0, 120'h4141, 1'b1, 2);

    run_txn("h_same_cycle", '{8'h48}, 1, 120'h48, 1'b1, 0);

    // word_end and a stray finish with an empty buffer change nothing.
    @(negedge clk);
    bus.i_word_end = 1'b1;
    @(negedge clk);
    bus.i_word_end   = 1'b0;
    bus.i_DTW_finish = 1'b1;
    bus.i_DTW_word   = 120'h4142;
    @(negedge clk);
    bus.i_DTW_finish = 1'b0;
    starts = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_state != 3'd0 || bus.o_DTW_start || bus.o_res_valid) starts++;
    end
    check("empty_word_end_ignored", starts, 0);

    run_txn("idle_x", '{8'h58}, 2, 120'h0, 1'b1, 0);
    run_txn("timeout", '{8'h51, 8'h52}, 1, 120'h0, 1'b0, 0);
    run_txn("toggle", '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F}, 0,
            120'h444C524F57, 1'b1, 1);

    for (int t = 0; t < 8; t++) begin
      q = {};
      n = $urandom_range(1, 18);
      for (int i = 0; i < n; i++)
        q.push_back(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      q[0] = 8'($urandom_range(1, 255));
      n = $urandom_range(0, 15);
      r = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 15; i++)
        if (i < n) begin
          if (r[i*8 +: 8] == 8'h00) r[i*8 +: 8] = 8'h61;
        end else if (i == n) r[i*8 +: 8] = 8'h00;
      run_txn("rand", q, int'($urandom_range(0, 1)), r, 1'b1, 2);
    end

    check("err_sticky", bus.o_err, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("err_cleared_by_rst", bus.o_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
